// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per enabled clock, start/busy/done handshake.
// Divide by zero skips the iterations and reports all-ones quotient with the dividend's low bits.
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          div_zero,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder
);
    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dsr;
    logic [VW:0]   rem;
    logic [CW-1:0] cnt;
    logic [VW:0]   shifted;
    logic          fit;

    // The extra remainder bit keeps the trial compare from overflowing.
    always_comb begin
        shifted = {rem[VW-1:0], dvd[DW-1]};
        fit     = (shifted >= {1'b0, dsr});
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else if (ena)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (divisor == '0) ? FIN : CALC;
            CALC: if (cnt == LAST) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // dvd doubles as the quotient shift register once the iterations start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (ena) begin
            busy <= (state_nxt != IDLE);
            done <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd <= dividend;
                        dsr <= divisor;
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    rem <= fit ? (shifted - {1'b0, dsr}) : shifted;
                    dvd <= {dvd[DW-2:0], fit};
                    cnt <= cnt + CW'(1);
                end
                FIN: begin
                    if (dsr == '0) begin
                        quotient  <= '1;
                        remainder <= dvd[VW-1:0];
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= dvd;
                        remainder <= rem[VW-1:0];
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider with hand-computed results and a product round-trip.
module tb_seq_divider;
    logic       clk = 1'b0;
    logic       rst, ena, start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy, done, div_zero;
    logic [7:0] quotient;
    logic [3:0] remainder;

    int n_chk = 0;
    int n_fail = 0;

    seq_divider #(.DW(8), .VW(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .div_zero(div_zero),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [7:0] a, input logic [3:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Counts cycles from the accepting edge (cycle c0 already elapsed) until done is seen.
    task automatic wait_done(input int c0, output int cyc, output int nbusy);
        cyc   = c0;
        nbusy = busy ? 1 : 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
            if (busy) nbusy++;
        end
        if (!done) chk("timeout", 0, 1);
    endtask

    task automatic div_case(input string tag, input logic [7:0] a, input logic [3:0] b,
                            input logic [7:0] eq, input logic [3:0] er, input logic ez,
                            input int elat);
        int cyc, nb;
        go(a, b);
        wait_done(1, cyc, nb);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, div_zero, ez);
        if (elat > 0) chk({tag, "_lat"}, cyc, elat);
        tick();
        chk({tag, "_done_clr"}, done, 0);
    endtask

    initial begin
        int cyc, nb, cnt;
        logic [7:0] sq;
        rst = 1'b0; ena = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        rst = 1'b1;
        tick();

        // Basic: busy for 9 cycles, done in cycle 10
        go(8'd200, 4'd7);
        wait_done(1, cyc, nb);
        chk("basic_lat", cyc, 10);
        chk("basic_busy", nb, 9);
        chk("basic_q", quotient, 28);
        chk("basic_r", remainder, 4);
        chk("basic_dz", div_zero, 0);
        tick();
        chk("basic_done_pulse", done, 0);

        div_case("e255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 10);
        div_case("e0_5", 8'd0, 4'd5, 8'd0, 4'd0, 1'b0, 10);
        div_case("e15_15", 8'd15, 4'd15, 8'd1, 4'd0, 1'b0, 10);
        div_case("e14_15", 8'd14, 4'd15, 8'd0, 4'd14, 1'b0, 10);
        div_case("dz100", 8'd100, 4'd0, 8'd255, 4'd4, 1'b1, 2);
        div_case("after_dz", 8'd100, 4'd10, 8'd10, 4'd0, 1'b0, 10);

        // start while busy is ignored
        go(8'd200, 4'd7);
        tick(); tick();
        dividend = 8'd50; divisor = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(4, cyc, nb);
        chk("hs_lat", cyc, 10);
        chk("hs_q", quotient, 28);
        chk("hs_r", remainder, 4);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done || busy) cnt++;
        end
        chk("hs_no_second", cnt, 0);

        // start coincident with done is accepted
        go(8'd100, 4'd10);
        wait_done(1, cyc, nb);
        chk("co_first_q", quotient, 10);
        go(8'd15, 4'd15);
        chk("co_busy", busy, 1);
        chk("co_done_clr", done, 0);
        wait_done(1, cyc, nb);
        chk("co_lat", cyc, 10);
        chk("co_q", quotient, 1);
        chk("co_r", remainder, 0);
        tick();

        // Stall mid-CALC
        go(8'd200, 4'd7);
        tick(); tick(); tick();
        ena = 1'b0;
        sq = quotient;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!busy || done || quotient != sq) cnt++;
        end
        chk("stall_frozen", cnt, 0);
        ena = 1'b1;
        wait_done(9, cyc, nb);
        chk("stall_lat", cyc, 15);
        chk("stall_q", quotient, 28);
        chk("stall_r", remainder, 4);
        // done holds while ena is low
        ena = 1'b0;
        tick(); tick();
        chk("stall_done_hold", done, 1);
        ena = 1'b1;
        tick();
        chk("stall_done_clr", done, 0);

        // Reset mid-CALC
        go(8'd200, 4'd7);
        tick(); tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_q", quotient, 0);
        chk("mrst_r", remainder, 0);
        chk("mrst_dz", div_zero, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) cnt++;
        end
        chk("mrst_no_done", cnt, 0);

        // Round-trip of every 4x4 product
        cnt = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                go(8'(a * b), 4'(b));
                wait_done(1, cyc, nb);
                if (b == 0) begin
                    if (div_zero !== 1'b1) cnt++;
                end else if (quotient !== 8'(a) || remainder !== 4'd0 || div_zero !== 1'b0) begin
                    cnt++;
                end
                tick();
            end
        end
        chk("roundtrip_errs", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
